// File: rtl/branch_ctrl.sv
// Branch/jump resolution controller: taken decision, PC redirect and wrong-path flush sequencing.
// Optional statistics counters are enabled by defining BRANCH_CTRL_STATS_EN.
module branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic             jmp_valid,
  input  logic [2:0]       br_funct3,
  input  logic             stall,
  input  logic             BrEq,
  input  logic             BrLt,
  output logic             BrUn,
  output logic             pc_sel,
  output logic             flush,
  output logic             busy,
  output logic             illegal
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
`endif
);

  localparam int unsigned FlushCntW = 3;

  typedef enum logic {
    StIdle  = 1'b0,
    StFlush = 1'b1
  } stateT;

  stateT                state;
  stateT                stateNext;
  logic [FlushCntW-1:0] flushCnt;
  logic [FlushCntW-1:0] flushCntNext;
  logic                 brTaken;
  logic                 resolve;
  logic                 taken;
  logic                 illegalNext;

  assign BrUn = br_funct3[1];

  // Branch condition decode; reserved encodings fall through as not-taken.
  always_comb begin
    brTaken = 1'b0;
    case (br_funct3)
      3'b000:  brTaken = BrEq;
      3'b001:  brTaken = !BrEq;
      3'b100:  brTaken = BrLt;
      3'b101:  brTaken = !BrLt;
      3'b110:  brTaken = BrLt;
      3'b111:  brTaken = !BrLt;
      default: brTaken = 1'b0;
    endcase
  end

  // Next-state, redirect and flush counter control.
  always_comb begin
    stateNext    = state;
    flushCntNext = flushCnt;
    resolve      = 1'b0;
    taken        = 1'b0;
    pc_sel       = 1'b0;
    illegalNext  = 1'b0;
    case (state)
      StIdle: begin
        if (rst_n && !stall && (br_valid || jmp_valid)) begin
          resolve     = 1'b1;
          taken       = jmp_valid || brTaken;
          pc_sel      = taken;
          illegalNext = !jmp_valid && (br_funct3[2:1] == 2'b01);
          if (taken) begin
            stateNext    = StFlush;
            flushCntNext = FlushCntW'(FLUSH_CYCLES);
          end
        end
      end
      StFlush: begin
        // Wrong-path instructions are ignored; only unstalled cycles count down.
        if (!stall) begin
          if (flushCnt <= FlushCntW'(1)) begin
            stateNext    = StIdle;
            flushCntNext = '0;
          end else begin
            flushCntNext = flushCnt - FlushCntW'(1);
          end
        end
      end
      default: begin
        stateNext    = StIdle;
        flushCntNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIdle;
      flushCnt <= '0;
      flush    <= 1'b0;
      busy     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= stateNext;
      flushCnt <= flushCntNext;
      flush    <= (stateNext == StFlush);
      busy     <= (stateNext == StFlush);
      illegal  <= illegalNext;
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  // Resolution statistics, wrapping at the counter width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else begin
      if (resolve) br_cnt <= br_cnt + CNT_W'(1);
      if (taken)   taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, SHALL set the number of wrong-path bubble cycles after a taken redirect (legal range 1..7).
REQ-002 Parameter CNT_W, default 32, SHALL set the width of the statistics counters.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 br_valid  input  1  EX stage holds a B-type instruction.
REQ-006 jmp_valid  input  1  EX stage holds JAL/JALR (unconditional).
REQ-007 br_funct3  input  3  funct3 of the EX-stage instruction.
REQ-008 stall  input  1  pipeline hold from the hazard/memory logic.
REQ-009 BrEq  input  1  equality result from the branch comparator.
REQ-010 BrLt  input  1  less-than result from the branch comparator.
REQ-011 BrUn  output  1  unsigned-compare select to the comparator.
REQ-012 pc_sel  output  1  1 = redirect PC to the branch/jump target.
REQ-013 flush  output  1  kill IF/ID instructions this cycle.
REQ-014 busy  output  1  controller is in FLUSH state.
REQ-015 illegal  output  1  one-cycle pulse flagging a reserved funct3 on br_valid.

Function
REQ-016 BrUn SHALL equal br_funct3[1] combinationally, regardless of state.
REQ-017 Taken condition: 000 BEQ=BrEq; 001 BNE=!BrEq; 100 BLT=BrLt; 101 BGE=!BrLt; 110 BLTU=BrLt; 111 BGEU=!BrLt; 010/011 SHALL be not-taken.
REQ-018 A resolution SHALL occur in a cycle where state=IDLE, stall=0, and br_valid or jmp_valid is 1; jmp_valid SHALL always be taken and SHALL take priority over br_valid.
REQ-019 pc_sel SHALL be combinational, asserted only in the resolution cycle of a taken instruction (zero latency).
REQ-020 On a taken resolution the FSM SHALL move IDLE->FLUSH, loading a down-counter with FLUSH_CYCLES.
REQ-021 In FLUSH: flush=1 and busy=1; counter SHALL decrement on each cycle with stall=0 and hold when stall=1; on reaching 0 the FSM SHALL return to IDLE with flush=0 in the following cycle.
REQ-022 In FLUSH, br_valid/jmp_valid SHALL be ignored (wrong-path) and SHALL neither set pc_sel nor resolve.
REQ-023 Not-taken resolutions SHALL leave the FSM in IDLE with flush=0.
REQ-024 illegal SHALL be registered: high exactly one cycle after a resolution with br_valid=1, jmp_valid=0 and funct3 in {010,011}.
REQ-025 In IDLE with stall=1, pc_sel SHALL be 0 and no state change SHALL occur.

Reset
REQ-026 When rst_n=0 at a rising edge: state=IDLE, counter=0, flush=0, busy=0, illegal=0, pc_sel=0 from the next cycle, overriding any in-progress flush.
REQ-027 While rst_n=0, pc_sel SHALL be forced to 0 combinationally.

Configuration
REQ-028 Macro BRANCH_CTRL_STATS_EN: when defined, outputs br_cnt[CNT_W-1:0] and taken_cnt[CNT_W-1:0] SHALL exist, counting resolutions (branches and jumps) and taken resolutions respectively, wrapping modulo 2^CNT_W and cleared by reset; when undefined, these ports and counters SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-029 rst_n=0 2 cycles, then br_valid=1, funct3=000, BrEq=1 -> pc_sel=1 same cycle; flush=1, busy=1 for exactly 2 cycles; then IDLE.
REQ-030 funct3=110, BrLt=0 -> BrUn=1, pc_sel=0, flush never asserts; funct3=100, BrLt=1 -> BrUn=0, pc_sel=1.
REQ-031 Taken BNE, stall=1 on the 1st FLUSH cycle for 3 cycles -> flush held high 3+2=5 cycles total; br_valid=1 with BrEq=0 during FLUSH -> pc_sel stays 0.
REQ-032 jmp_valid=1 and br_valid=1 (funct3=000, BrEq=0) together -> pc_sel=1 (jump priority); br_valid=1, funct3=011 -> illegal=1 next cycle only, pc_sel=0.
REQ-033 rst_n=0 during the 1st FLUSH cycle -> next cycle flush=0, busy=0; new taken branch immediately after reset resolves normally.
REQ-034 With BRANCH_CTRL_STATS_EN, CNT_W=4: 17 taken branches -> br_cnt=1, taken_cnt=1 (wrap); without the macro the bench SHALL compile without the stats ports.
